// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer for the shared registered ALU: two valid/ready
// request ports in, operands out to the ALU, captured result back to the owner.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  input  logic [3:0]  req0_ctrl,
  input  logic [3:0]  req1_ctrl,
  output logic        resp0_valid,
  output logic        resp1_valid,
  input  logic        resp0_ready,
  input  logic        resp1_ready,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_cout,
  output logic        resp_overflow,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_cout,
  input  logic        alu_overflow,
  output logic        busy,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ctrl;
  } op_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;
  } rsp_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic            owner_q, owner_d;
  op_t             op_q, op_d;
  rsp_t            rsp_q, rsp_d;
  logic [1:0]      rvld_q, rvld_d;
  logic [15:0]     ops_q, ops_d;
  op_t [1:0]       req_op;
  logic [1:0]      resp_rdy;
  logic            grant, gnt_vld;

  assign req_op[0] = {req0_src1, req0_src2, req0_ctrl};
  assign req_op[1] = {req1_src1, req1_src2, req1_ctrl};
  assign resp_rdy  = {resp1_ready, resp0_ready};

  // Contention goes to prio; otherwise whichever single requester is valid.
  assign grant   = (req0_valid && req1_valid) ? prio_q : req1_valid;
  assign gnt_vld = req0_valid || req1_valid;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    op_d       = op_q;
    rsp_d      = rsp_q;
    rvld_d     = rvld_q;
    ops_d      = ops_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = rst_n && req0_valid && !grant;
        req1_ready = rst_n && req1_valid && grant;
        if (gnt_vld) begin
          op_d    = req_op[grant];
          owner_d = grant;
          state_d = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        rsp_d           = {alu_result, alu_zero, alu_cout, alu_overflow};
        rvld_d[owner_q] = 1'b1;
        state_d         = RESP;
      end
      RESP: begin
        if (resp_rdy[owner_q]) begin
          rvld_d  = '0;
          prio_d  = ~owner_q;
          ops_d   = ops_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      op_q    <= '0;
      rsp_q   <= '0;
      rvld_q  <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      rsp_q   <= rsp_d;
      rvld_q  <= rvld_d;
      ops_q   <= ops_d;
    end
  end

  assign alu_src1      = op_q.src1;
  assign alu_src2      = op_q.src2;
  assign alu_ctrl      = op_q.ctrl;
  assign resp_result   = rsp_q.result;
  assign resp_zero     = rsp_q.zero;
  assign resp_cout     = rsp_q.cout;
  assign resp_overflow = rsp_q.ovf;
  assign resp0_valid   = rvld_q[0];
  assign resp1_valid   = rvld_q[1];
  assign busy          = (state_q != IDLE);
  assign ops_done      = ops_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, transaction-level arbitration model,
// directed test-plan cases followed by randomized two-requester traffic.
module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
  } top_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp_result;
  logic        resp_zero, resp_cout, resp_overflow;
  logic [31:0] alu_src1, alu_src2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero, alu_cout, alu_overflow;
  logic        busy;
  logic [15:0] ops_done;

  int   checks = 0;
  int   errors = 0;
  bit   prio;
  int   exp_ops;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .resp_cout(resp_cout), .resp_overflow(resp_overflow),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .busy(busy), .ops_done(ops_done)
  );

  // Returns {result, zero, cout, overflow} for one ALU operation.
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        co, ov;
    co = 1'b0; ov = 1'b0; s = '0; r = '0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: r = a ^ b;
    endcase
    return {r, (r == 32'd0), co, ov};
  endfunction

  always @(posedge clk)
    {alu_result, alu_zero, alu_cout, alu_overflow} <= alu_f(alu_src1, alu_src2, alu_ctrl);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    prio = 1'b0; exp_ops = 0;
  endtask

  // One full transaction from an IDLE cycle (called at posedge+1).
  task automatic issue(input logic v0, input logic v1, input top_t o0, input top_t o1,
                       input int bp, output bit g);
    top_t        og;
    logic [34:0] e;
    req0_valid = v0; req0_src1 = o0.a; req0_src2 = o0.b; req0_ctrl = o0.c;
    req1_valid = v1; req1_src1 = o1.a; req1_src2 = o1.b; req1_ctrl = o1.c;
    g  = (v0 && v1) ? prio : v1;
    og = g ? o1 : o0;
    e  = alu_f(og.a, og.b, og.c);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_rdy0", req0_ready, !g);
    chk("idle_rdy1", req1_ready, g);
    @(posedge clk); #1;
    if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
    chk("exec_src1", alu_src1, og.a);
    chk("exec_src2", alu_src2, og.b);
    chk("exec_ctrl", alu_ctrl, og.c);
    chk("exec_busy", busy, 1);
    chk("exec_rdy", {req1_ready, req0_ready}, 0);
    @(posedge clk); #1;
    chk("capt_vld", {resp1_valid, resp0_valid}, 0);
    if (bp == 0) begin
      if (g) resp1_ready = 1'b1; else resp0_ready = 1'b1;
    end else begin
      if (g) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("resp_vld", {resp1_valid, resp0_valid}, g ? 2'b10 : 2'b01);
    chk("resp_data", {resp_result, resp_zero, resp_cout, resp_overflow}, e);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("hold_vld", {resp1_valid, resp0_valid}, g ? 2'b10 : 2'b01);
      chk("hold_data", {resp_result, resp_zero, resp_cout, resp_overflow}, e);
      chk("hold_rdy", {req1_ready, req0_ready}, 0);
      chk("hold_alu", {alu_src1, alu_src2, alu_ctrl}, og);
    end
    if (g) resp1_ready = 1'b1; else resp0_ready = 1'b1;
    @(posedge clk); #1;
    exp_ops++;
    prio = ~g;
    chk("done_vld", {resp1_valid, resp0_valid}, 0);
    chk("done_ops", ops_done, exp_ops[15:0]);
    chk("done_busy", busy, 0);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  initial begin
    top_t       o0, o1, z;
    bit         g, p0, p1;
    logic [3:0] codes [7];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};
    z = '0;
    req0_src1 = '0; req0_src2 = '0; req0_ctrl = '0;
    req1_src1 = '0; req1_src2 = '0; req1_ctrl = '0;

    // Reset state, with req0 already valid to show ready is held low.
    rst_n = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    req0_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", {req1_ready, req0_ready}, 0);
    chk("rst_vld", {resp1_valid, resp0_valid}, 0);
    chk("rst_resp", {resp_result, resp_zero, resp_cout, resp_overflow}, 0);
    chk("rst_alu", {alu_src1, alu_src2, alu_ctrl}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops", ops_done, 0);
    req0_valid = 1'b0;
    rst_n = 1'b1; prio = 1'b0; exp_ops = 0;
    @(posedge clk); #1;

    // Directed test-plan cases.
    issue(1, 0, '{32'd5, 32'd3, 4'b0010}, z, 0, g);
    issue(0, 1, z, '{32'd3, 32'd3, 4'b0110}, 0, g);
    issue(1, 0, '{32'h7FFFFFFF, 32'h1, 4'b0010}, z, 0, g);

    // Round-robin with both requests held from reset.
    do_reset();
    o0 = '{32'h1234, 32'h00FF, 4'b0000};
    o1 = '{32'hFFFFFFFF, 32'h1, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      issue(1, 1, o0, o1, 0, g);
      chk("rr_grant", g, i % 2);
    end

    // Back-pressure: req0 held in RESP for 10 cycles, then req1 served.
    issue(1, 1, '{32'hA5A5A5A5, 32'h5A5A5A5A, 4'b0001}, o1, 10, g);
    chk("bp_grant0", g, 0);
    issue(0, 1, z, o1, 0, g);
    chk("bp_grant1", g, 1);

    // Reset during EXEC drops the operation.
    req0_valid = 1'b1; req0_src1 = 32'd9; req0_src2 = 32'd4; req0_ctrl = 4'b0110;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_alu", {alu_src1, alu_src2, alu_ctrl}, 0);
    chk("mid_rst_resp", {resp_result, resp_zero, resp_cout, resp_overflow}, 0);
    chk("mid_rst_vld", {resp1_valid, resp0_valid}, 0);
    chk("mid_rst_ops", ops_done, 0);
    chk("mid_rst_rdy", {req1_ready, req0_ready}, 0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; prio = 1'b0; exp_ops = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_vld", {resp1_valid, resp0_valid}, 0);
      chk("post_rst_busy", busy, 0);
    end
    issue(1, 0, '{32'd9, 32'd4, 4'b0110}, z, 0, g);

    // Randomized traffic; a loser keeps its operation pending until granted.
    p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1'b1;
        o0.a = $urandom;
        o0.b = ($urandom_range(0, 3) == 0) ? o0.a : $urandom;
        o0.c = codes[$urandom_range(0, 6)];
      end
      if (!p1 && ($urandom_range(0, 1) == 1 || !p0)) begin
        p1 = 1'b1;
        o1.a = $urandom;
        o1.b = ($urandom_range(0, 3) == 0) ? o1.a : $urandom;
        o1.c = codes[$urandom_range(0, 6)];
      end
      issue(p0, p1, o0, o1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0, g);
      if (g) p1 = 1'b0; else p0 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 32-bit registered ALU. It accepts operations over valid/ready request ports and drives the ALU operand/control inputs from registers. It then captures the ALU's registered result/flags one cycle later and returns them to the owning requester over a valid/ready response port. It sits between the ALU and its two clients (e.g. the datapath issue stage and the branch-compare unit).

## Interface
- No parameters; data width fixed at 32, control width fixed at 4.
- clk  in  1  clock; also clocks the ALU
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  request pending
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_src1, req0_src2 / req1_src1, req1_src2  in  32  operands
- req0_ctrl / req1_ctrl  in  4  ALU_control code, passed through undecoded
- resp0_valid / resp1_valid  out  1  response for that requester
- resp0_ready / resp1_ready  in  1  requester takes response
- resp_result  out  32  shared response data
- resp_zero, resp_cout, resp_overflow  out  1  shared response flags
- alu_src1, alu_src2  out  32  to ALU
- alu_ctrl  out  4  to ALU
- alu_result  in  32  from ALU, registered inside the ALU
- alu_zero, alu_cout, alu_overflow  in  1  from ALU
- busy  out  1  high in any state other than IDLE
- ops_done  out  16  completed-operation counter, wraps

## Operation
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE, grant selection:
  - If both requests are valid, grant the requester named by the prio pointer.
  - If only one request is valid, grant it.
  - reqN_ready is combinational: state==IDLE && grant==N. At most one ready is high.
- IDLE, accept edge (valid&&ready):
  - Latch that requester's src1/src2/ctrl into the alu_* registers.
  - Record owner.
  - Go to EXEC.
- EXEC: alu_* held stable; the ALU registers its result at the end of this cycle; go to CAPT.
- CAPT:
  - alu_result and the alu flags are valid.
  - Latch them into the resp_* registers.
  - Set resp<owner>_valid.
  - Go to RESP.
- RESP:
  - Hold resp<owner>_valid and all resp_* stable until resp<owner>_ready.
  - On that handshake edge:
    - Clear valid.
    - Set prio <= ~owner.
    - Increment ops_done (mod 2^16).
    - Go to IDLE.
- Requester rules:
  - A requester must hold valid and its operands until ready.
  - The arbiter never takes requests outside IDLE.
  - The non-owner's resp_valid is always 0.
- alu_* registers keep their last value outside accept edges.
- ALU codes used by clients: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR. Any code is forwarded verbatim.

## Timing
- Reset values, applied immediately on rst_n low:
  - state=IDLE, prio=0, owner=0.
  - req*_ready=0 while in reset.
  - resp*_valid=0, resp_result=0, resp flags=0.
  - alu_src1=alu_src2=0, alu_ctrl=0.
  - busy=0, ops_done=0.
- Latency: accept at edge E0 -> resp valid from edge E2, i.e. two cycles after acceptance.
- Throughput: the minimum is one operation per 4 cycles, when resp_ready is already high in RESP.
- Request during busy: ready stays 0; the request waits without loss.
- Simultaneous events:
  - Both requests valid in IDLE: only the prio requester is readied.
  - The loser is served next, provided it is still valid when the arbiter returns to IDLE.
- Back-pressure: resp_ready low holds the FSM in RESP indefinitely. No new grants are made and outputs are unchanged.
- Reset mid-operation (any state):
  - All state returns to reset values.
  - The in-flight operation is dropped and no response is produced.
  - The requester re-issues after reset.
- ops_done wraps from 0xFFFF to 0x0000.

## Test plan
- Single request: req0 ADD (ctrl 0010) 5+3 -> req0_ready for 1 cycle; resp0_valid 2 cycles later; result 0x00000008, zero=0, cout=0, overflow=0; ops_done=1.
- Zero/carry: req1 SUB (0110) 3-3 -> resp1_valid with result 0, zero=1, cout=1, overflow=0; resp0_valid stays 0.
- Overflow: req0 ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow=1, cout=0.
- Round-robin: both requests held valid from reset -> grants alternate 0,1,0,1 over 4 operations; each response is routed only to its owner.
- Back-pressure: resp0_ready low for 10 cycles -> resp0_valid and the data are stable; req1 is not readied; after the ready handshake, req1 is granted in the next IDLE cycle.
- Reset: assert rst_n low during EXEC -> all outputs read reset values immediately; after release, no response appears; a new request completes normally.
